if_fetch_ctrl: RTL

// - Instruction-fetch sequencer for the pipelined MIPS core: owns the fetch PC, drives the

---
 rtl/if_fetch_ctrl_pkg.sv | 14 +
 rtl/if_fetch_ctrl_fetch_q2.sv | 66 ++++++
 rtl/if_fetch_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch constants and the queue entry type.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam int          DEF_IM_WORDS = 1024;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_ent_t;

endpackage

// File: rtl/if_fetch_ctrl_fetch_q2.sv
// Two-entry {pc,instr} FIFO; head and last-popped entry are register outputs.
// Latency: a push is visible at dout the next cycle. Backpressure: push is ignored when full without a pop.
// Flush empties the queue but keeps the last-popped entry shown on dout.
module fetch_q2
    import if_fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_ent_t din,
    output fetch_ent_t dout,
    output logic [1:0] count
);

    fetch_ent_t mem0_q, mem0_d;
    fetch_ent_t mem1_q, mem1_d;
    fetch_ent_t last_q, last_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok, push_ok;

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        last_d  = last_q;
        count_d = count_q;
        pop_ok  = pop & (count_q != 2'd0);
        push_ok = push & ((count_q != 2'd2) | pop_ok);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_ok) begin
                last_d = mem0_q;
                mem0_d = mem1_q;
            end
            // After a pop, the slot that receives the push shifts down by one.
            if (push_ok) begin
                if ((count_q == 2'd0) || (count_q == 2'd1 && pop_ok)) begin
                    mem0_d = din;
                end else begin
                    mem1_d = din;
                end
            end
            count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            last_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign dout  = (count_q != 2'd0) ? mem0_q : last_q;
    assign count = count_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational ROM and queues words to decode.
// Latency: a word fetched at edge N is at the head from edge N+1. Backpressure: 2-entry queue, ROM never re-read.
// Redirect flushes the queue and reloads the PC; an illegal PC suspends fetch until redirect/reset.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          IM_WORDS = DEF_IM_WORDS
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [31:0]        im_pc,
    input  logic [INSTR_W-1:0] im_code,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic               addr_err,
    output logic [31:0]        fetch_cnt
);

    localparam logic [31:0] PC_END = RESET_PC + 32'(4 * IM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [1:0]  q_count;
    logic        deq, fetch;
    fetch_ent_t  q_din, q_dout;

    assign addr_err  = (pc_q < RESET_PC) | (pc_q >= PC_END);
    assign out_valid = (q_count != 2'd0);
    assign deq       = out_valid & out_ready & ~redirect_valid;
    assign fetch     = ~redirect_valid & ~halt & ~addr_err & ((q_count != 2'd2) | deq);
    assign q_din     = '{pc: pc_q, instr: im_code};

    always_comb begin
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'd3;
        end else if (fetch) begin
            // Wraps mod 2^32; the wrapped PC is out of range and raises addr_err.
            pc_d        = pc_q + 32'd4;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    fetch_q2 u_fetch_q2 (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fetch),
        .pop     (deq),
        .flush   (redirect_valid),
        .din     (q_din),
        .dout    (q_dout),
        .count   (q_count)
    );

    assign im_pc     = pc_q;
    assign out_instr = q_dout.instr;
    assign out_pc    = q_dout.pc;
    assign fetch_cnt = fetch_cnt_q;

endmodule
